reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised next-generation register file for the datapath.
- Two independent combinational read ports, one synchronous write port, and an optional hardwired-zero register 0.
- A hardware clear sequencer zeroes the whole array on command, one entry per cycle, signalling Busy meanwhile.
- Sits between decode (read addresses) and writeback (write port); used wherever the core needs a bulk register wipe without a global reset.

Parameters:
- W, 8, data width in bits.
- D, 3, address width; depth = 2**D entries.
- ZERO_R0, 1, 1 = register 0 reads as 0 and ignores writes; 0 = register 0 is an ordinary entry.

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- WriteEn  in  1  write request for this cycle.
- Waddr  in  D  write address.
- DataIn  in  W  write data.
- RaddrA  in  D  read address, port A.
- RaddrB  in  D  read address, port B.
- DataOutA  out  W  combinational read data, port A.
- DataOutB  out  W  combinational read data, port B.
- ClearReq  in  1  single-cycle request to zero all entries.
- Busy  out  1  high while the clear sweep is running.

Behaviour:
- Reset (Reset_n low, asynchronous): all entries = 0, FSM = IDLE, sweep counter = 0, Busy = 0.
  - Reset overrides everything, including a sweep in progress; after release the block is in IDLE.
- Reads:
  - Purely combinational from the array (zero latency).
  - If ZERO_R0 = 1, address 0 always returns 0.
- Writes:
  - Committed at posedge when WriteEn = 1 and Busy = 0.
  - If ZERO_R0 = 1 and Waddr = 0, the write is discarded.
  - While Busy = 1, WriteEn is ignored; the write is lost and the requester must retry.
- FSM states:
  - IDLE: Busy = 0.
  - SWEEP: Busy = 1.
- Transitions:
  - IDLE -> SWEEP on ClearReq = 1. Counter loads 0; Busy rises the following cycle.
  - In SWEEP, each cycle: entry[counter] <= 0, then counter increments.
  - When counter = 2**D-1, that entry is cleared, counter wraps to 0, and the FSM returns to IDLE.
  - Busy is high for exactly 2**D cycles.
- ClearReq while Busy = 1: ignored; no restart, no queueing.
- ClearReq and a valid WriteEn in the same IDLE cycle: the write commits, the sweep starts next cycle, and the sweep later zeroes that entry.
- Reads during SWEEP return current array contents: entries below the counter read 0, entries at or above it read old data.
- Counter width: D bits; wrap-around is natural modulo 2**D.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding on each read port, evaluated per port.
  - Forwarding applies when WriteEn = 1, Busy = 0, Raddr = Waddr, and the write is not discarded by ZERO_R0.
  - When it applies, DataOut = DataIn in the same cycle.
- Not defined: reads return the pre-write value until the edge after the write.
- Busy and ZERO_R0 behaviour are identical in both builds.

Decomposition:
- Package regfile_pkg:
  - typedef enum logic {IDLE, SWEEP} clr_state_t.
  - localparam defaults for W and D.
- One sub-module: regfile_clear_seq.
  - Contains the FSM, sweep counter and Busy.
  - Outputs: ClrEn, ClrAddr.
  - The top-level array applies the clear write with priority over the normal write port.

Test Plan:
- Reset then read: after Reset_n low->high, all addresses on both ports read 0x00.
- Write/readback (W=8, D=3): write 0xA5 to r3 and 0x3C to r7; RaddrA=3, RaddrB=7 next cycle -> DataOutA=0xA5, DataOutB=0x3C.
- r0 handling: ZERO_R0=1, write 0xFF to r0 -> reads 0x00; ZERO_R0=0 -> reads 0xFF.
- Bypass: write 0x5A to r2 with RaddrA=2 in the same cycle, r2 previously 0x11 -> DataOutA=0x5A with REGFILE_BYPASS_EN, 0x11 without; both builds read 0x5A the next cycle.
- Clear sweep: fill r1..r7 nonzero, pulse ClearReq -> Busy high exactly 8 cycles; a write of 0x77 to r4 during Busy is dropped; after Busy falls all entries read 0; a second ClearReq mid-sweep does not extend Busy.
- Reset mid-sweep: assert Reset_n low on the 3rd Busy cycle -> Busy drops immediately and all entries read 0; after release, a ClearReq gives a full 8-cycle sweep.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Imported by the clear sequencer and the reg_file_mp top.
package regfile_pkg;

   localparam int W_DEF = 8;
   localparam int D_DEF = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } clr_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every entry once, emitting one clear write per cycle.
// The FSM state is exported on State so checkers can bind to it directly.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int D = D_DEF
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         ClearReq,
   output logic         Busy,
   output logic         ClrEn,
   output logic [D-1:0] ClrAddr,
   output clr_state_t   State
);

   clr_state_t   state_q, state_d;
   logic [D-1:0] cnt_q, cnt_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ClearReq is only sampled in IDLE; once the sweep runs, further requests
   // are dropped rather than queued, so Busy is exactly 2**D cycles long.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (ClearReq) begin
               state_d = SWEEP;
               cnt_d   = '0;
            end
         end
         SWEEP: begin
            cnt_d = cnt_q + D'(1);
            if (&cnt_q) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign Busy    = (state_q == SWEEP);
   assign ClrEn   = (state_q == SWEEP);
   assign ClrAddr = cnt_q;
   assign State   = state_q;

endmodule : regfile_clear_seq

// File: rtl/reg_file_mp.sv
// Register file: two combinational read ports, one write port, bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int W       = W_DEF,
   parameter int D       = D_DEF,
   parameter int ZERO_R0 = 1
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         WriteEn,
   input  logic [D-1:0] Waddr,
   input  logic [W-1:0] DataIn,
   input  logic [D-1:0] RaddrA,
   input  logic [D-1:0] RaddrB,
   output logic [W-1:0] DataOutA,
   output logic [W-1:0] DataOutB,
   input  logic         ClearReq,
   output logic         Busy
);

   localparam int DEPTH = 1 << D;

   logic [W-1:0] mem [DEPTH];
   logic         clr_en;
   logic [D-1:0] clr_addr;
   clr_state_t   clr_state;
   logic         wr_ok;
   logic [W-1:0] rd_a, rd_b;

   regfile_clear_seq #(
      .D (D)
   ) u_clear_seq (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .ClearReq (ClearReq),
      .Busy     (Busy),
      .ClrEn    (clr_en),
      .ClrAddr  (clr_addr),
      .State    (clr_state)
   );

   // A write is accepted only outside the sweep and never to a hardwired r0.
   assign wr_ok = WriteEn && (clr_state == IDLE) &&
                  !((ZERO_R0 != 0) && (Waddr == '0));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clr_en) begin
         mem[clr_addr] <= '0;
      end else if (wr_ok) begin
         mem[Waddr] <= DataIn;
      end
   end

   always_comb begin
      rd_a = mem[RaddrA];
      if ((ZERO_R0 != 0) && (RaddrA == '0)) begin
         rd_a = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (RaddrA == Waddr)) begin
         rd_a = DataIn;
      end
`endif
   end

   always_comb begin
      rd_b = mem[RaddrB];
      if ((ZERO_R0 != 0) && (RaddrB == '0)) begin
         rd_b = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (RaddrB == Waddr)) begin
         rd_b = DataIn;
      end
`endif
   end

   assign DataOutA = rd_a;
   assign DataOutB = rd_b;

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance with hardwired r0, one without.
// Expectations for same-cycle reads follow the REGFILE_BYPASS_EN build.
module tb_reg_file_mp;

   logic       Clk;
   logic       Reset_n;
   logic       WriteEn;
   logic [2:0] Waddr;
   logic [7:0] DataIn;
   logic [2:0] RaddrA, RaddrB;
   logic       ClearReq;
   logic [7:0] DataOutA, DataOutB, DataOutA0, DataOutB0;
   logic       Busy, Busy0;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   reg_file_mp #(.W(8), .D(3), .ZERO_R0(1)) u_dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .WriteEn  (WriteEn),
      .Waddr    (Waddr),
      .DataIn   (DataIn),
      .RaddrA   (RaddrA),
      .RaddrB   (RaddrB),
      .DataOutA (DataOutA),
      .DataOutB (DataOutB),
      .ClearReq (ClearReq),
      .Busy     (Busy)
   );

   reg_file_mp #(.W(8), .D(3), .ZERO_R0(0)) u_dut0 (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .WriteEn  (WriteEn),
      .Waddr    (Waddr),
      .DataIn   (DataIn),
      .RaddrA   (RaddrA),
      .RaddrB   (RaddrB),
      .DataOutA (DataOutA0),
      .DataOutB (DataOutB0),
      .ClearReq (ClearReq),
      .Busy     (Busy0)
   );

   // clock / reset
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic [7:0] data);
      WriteEn = 1'b1;
      Waddr   = 3'(addr);
      DataIn  = data;
      step();
      WriteEn = 1'b0;
   endtask

   task automatic fill();
      for (int i = 1; i < 8; i++) begin
         wr(i, 8'(8'h10 + i));
      end
   endtask

   task automatic chk_zero(input string tag);
      for (int a = 0; a < 8; a++) begin
         RaddrA = 3'(a);
         RaddrB = 3'(7 - a);
         #1;
         chk({tag, "_a"},  DataOutA,  32'h0);
         chk({tag, "_b"},  DataOutB,  32'h0);
         chk({tag, "_a0"}, DataOutA0, 32'h0);
         chk({tag, "_b0"}, DataOutB0, 32'h0);
      end
   endtask

   task automatic run_sweep(output int n);
      n = 0;
      ClearReq = 1'b1;
      for (int w = 1; w <= 20; w++) begin
         step();
         ClearReq = 1'b0;
         if (!Busy) break;
         n++;
      end
   endtask

   initial begin
      int n, n0;
      Reset_n  = 1'b0;
      WriteEn  = 1'b0;
      Waddr    = '0;
      DataIn   = '0;
      RaddrA   = '0;
      RaddrB   = '0;
      ClearReq = 1'b0;
      repeat (2) step();
      chk("busy_in_reset", Busy, 32'h0);
      Reset_n = 1'b1;
      step();
      chk("busy_after_reset", Busy, 32'h0);
      chk_zero("reset_read");

      // write / readback
      wr(3, 8'hA5);
      wr(7, 8'h3C);
      exp_q.push_back(32'hA5);
      exp_q.push_back(32'h3C);
      RaddrA = 3'd3;
      RaddrB = 3'd7;
      #1;
      chk("rb_a0", DataOutA0, exp_q[0]);
      chk("rb_b0", DataOutB0, exp_q[1]);
      chk("rb_a", DataOutA, exp_q.pop_front());
      chk("rb_b", DataOutB, exp_q.pop_front());

      // r0 handling
      wr(0, 8'hFF);
      RaddrA = 3'd0;
      RaddrB = 3'd0;
      #1;
      chk("r0_zero", DataOutA, 32'h00);
      chk("r0_zero_b", DataOutB, 32'h00);
      chk("r0_plain", DataOutA0, 32'hFF);

      // same-cycle read of a write in flight
      wr(2, 8'h11);
      WriteEn = 1'b1;
      Waddr   = 3'd2;
      DataIn  = 8'h5A;
      RaddrA  = 3'd2;
      RaddrB  = 3'd7;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_a", DataOutA, 32'h5A);
      chk("byp_a0", DataOutA0, 32'h5A);
`else
      chk("byp_a", DataOutA, 32'h11);
      chk("byp_a0", DataOutA0, 32'h11);
`endif
      chk("byp_other_port", DataOutB, 32'h3C);
      step();
      WriteEn = 1'b0;
      #1;
      chk("byp_next_a", DataOutA, 32'h5A);
      chk("byp_next_a0", DataOutA0, 32'h5A);

      // discarded r0 write must never be forwarded
      WriteEn = 1'b1;
      Waddr   = 3'd0;
      DataIn  = 8'hEE;
      RaddrA  = 3'd0;
      #1;
      chk("byp_r0", DataOutA, 32'h00);
`ifdef REGFILE_BYPASS_EN
      chk("byp_r0_plain", DataOutA0, 32'hEE);
`else
      chk("byp_r0_plain", DataOutA0, 32'hFF);
`endif
      step();
      WriteEn = 1'b0;
      #1;
      chk("r0_plain_next", DataOutA0, 32'hEE);

      // clear sweep with dropped write and ignored second request
      fill();
      n  = 0;
      n0 = 0;
      ClearReq = 1'b1;
      for (int w = 1; w <= 20; w++) begin
         step();
         ClearReq = 1'b0;
         WriteEn  = 1'b0;
         if (!Busy) break;
         n++;
         if (Busy0) n0++;
         if (w == 2) begin
            WriteEn = 1'b1;
            Waddr   = 3'd4;
            DataIn  = 8'h77;
         end
         if (w == 3) begin
            RaddrA = 3'd4;
            RaddrB = 3'd1;
            #1;
            chk("sweep_r4_old", DataOutA, 32'h14);
            chk("sweep_r4_old0", DataOutA0, 32'h14);
            chk("sweep_r1_clr", DataOutB, 32'h00);
            chk("sweep_r1_clr0", DataOutB0, 32'h00);
         end
         if (w == 4) ClearReq = 1'b1;
      end
      chk("sweep_len", 32'(n), 32'd8);
      chk("sweep_len0", 32'(n0), 32'd8);
      chk_zero("after_sweep");
      step();
      chk("no_requeue", Busy, 32'h0);

      wr(5, 8'h99);
      RaddrA = 3'd5;
      #1;
      chk("post_sweep_wr", DataOutA, 32'h99);

      // reset in the middle of a sweep
      fill();
      wr(0, 8'hC3);
      ClearReq = 1'b1;
      step();
      ClearReq = 1'b0;
      repeat (2) step();
      chk("mid_busy", Busy, 32'h1);
      Reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", Busy, 32'h0);
      chk_zero("mid_rst");
      step();
      Reset_n = 1'b1;
      step();
      chk("rel_busy", Busy, 32'h0);
      run_sweep(n);
      chk("sweep_after_rst", 32'(n), 32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_reg_file_mp
